// File: rtl/rs_dsp_acc_drain_pkg.sv
// Shared constants, FSM state type and product-extension helper for the
// DSP38 product accumulator.
package rs_dsp_acc_pkg;

    localparam int Z_W       = 38;
    localparam int EXT_MAX_W = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Callers truncate the result to their own ACC_W; the low bits are the
    // same for every width because the extension is uniform above Z_W.
    function automatic logic [EXT_MAX_W-1:0] ext_product(
        input logic [Z_W-1:0] z,
        input logic           signed_flag
    );
        logic [EXT_MAX_W-1:0] r;
        r = {{(EXT_MAX_W-Z_W){signed_flag & z[Z_W-1]}}, z};
        return r;
    endfunction

endpackage

// File: rtl/rs_dsp_acc_drain_if.sv
// Product-in / frame-sum-out bundle between the multiplier side and the
// accumulator; master drives products and ready, slave returns results.
interface rs_dsp_acc_drain_if #(
    parameter int ACC_W = 48,
    parameter int LEN_W = 8
);
    import rs_dsp_acc_pkg::*;

    logic [Z_W-1:0]   z;
    logic             z_valid;
    logic             z_signed;
    logic [LEN_W-1:0] frame_len;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             sat;

    modport master (
        output z, z_valid, z_signed, frame_len, acc_ready,
        input  acc_out, acc_valid, sat
    );

    modport slave (
        input  z, z_valid, z_signed, frame_len, acc_ready,
        output acc_out, acc_valid, sat
    );

endinterface

// File: rtl/rs_dsp_acc_outbuf.sv
// One-entry valid/ready result register; a load into a full, undrained
// entry is discarded and latched into the sticky drop flag.
module rs_dsp_acc_outbuf #(
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             lreset,
    input  logic             load,
    input  logic [ACC_W-1:0] load_data,
    input  logic             load_sat,
    input  logic             ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic             drop_err
);

    logic             valid_q, valid_d;
    logic [ACC_W-1:0] data_q,  data_d;
    logic             sat_q,   sat_d;
    logic             drop_q,  drop_d;
    logic             accept;

    assign accept = valid_q && ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        sat_d   = sat_q;
        drop_d  = drop_q;

        if (accept) begin
            valid_d = 1'b0;
        end

        // A drain in the same cycle frees the slot for the new result.
        if (load) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                data_d  = load_data;
                sat_d   = load_sat;
            end else begin
                drop_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (lreset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign drop_err  = drop_q;

endmodule

// File: rtl/rs_dsp_acc_drain.sv
// Frame accumulator for the registered DSP38 product stream. Optional
// saturating adder enabled by defining RS_DSP_ACC_SAT_EN.
module rs_dsp_acc_drain
    import rs_dsp_acc_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 lreset,
    rs_dsp_acc_drain_if.slave    bus,
    output logic                 busy,
    output logic                 drop_err
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt_inc;
    logic [ACC_W-1:0] ext_w;
    logic [ACC_W-1:0] add_sum;
    logic             done;
    logic             frame_sat;

    assign ext_w   = ACC_W'(ext_product(bus.z, bus.z_signed));
    assign len_eff = (bus.frame_len == '0) ? LEN_W'(1) : bus.frame_len;
    assign cnt_inc = cnt_q + LEN_W'(1);

`ifdef RS_DSP_ACC_SAT_EN
    logic [ACC_W:0] wide_sum;
    logic           add_clamp;
    logic           fsat_q, fsat_d;

    // Signed overflow shows as disagreement between the two top bits;
    // unsigned overflow as a carry out of the ACC_W-bit sum.
    always_comb begin
        add_clamp = 1'b0;
        if (bus.z_signed) begin
            wide_sum = {acc_q[ACC_W-1], acc_q} + {ext_w[ACC_W-1], ext_w};
            add_sum  = wide_sum[ACC_W-1:0];
            if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
                add_clamp = 1'b1;
                add_sum   = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                            : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            wide_sum = {1'b0, acc_q} + {1'b0, ext_w};
            add_sum  = wide_sum[ACC_W-1:0];
            if (wide_sum[ACC_W]) begin
                add_clamp = 1'b1;
                add_sum   = '1;
            end
        end
    end

    always_comb begin
        fsat_d = fsat_q;
        if (bus.z_valid) begin
            fsat_d = (state_q == IDLE) ? 1'b0 : (fsat_q | add_clamp);
        end
    end

    always_ff @(posedge clk) begin
        if (lreset) begin
            fsat_q <= 1'b0;
        end else begin
            fsat_q <= fsat_d;
        end
    end

    assign frame_sat = fsat_d;
`else
    assign add_sum   = acc_q + ext_w;
    assign frame_sat = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        acc_d   = acc_q;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.z_valid) begin
                    acc_d = ext_w;
                    cnt_d = LEN_W'(1);
                    len_d = len_eff;
                    if (len_eff == LEN_W'(1)) begin
                        done = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (bus.z_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (lreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
        end
    end

    // On a completing cycle acc_d already holds the final frame sum.
    rs_dsp_acc_outbuf #(
        .ACC_W (ACC_W)
    ) u_outbuf (
        .clk       (clk),
        .lreset    (lreset),
        .load      (done),
        .load_data (acc_d),
        .load_sat  (frame_sat),
        .ready     (bus.acc_ready),
        .out_valid (bus.acc_valid),
        .out_data  (bus.acc_out),
        .out_sat   (bus.sat),
        .drop_err  (drop_err)
    );

    assign busy = (state_q == ACCUM);

endmodule

// File: tb/tb_rs_dsp_acc_drain.sv
// Self-checking bench for rs_dsp_acc_drain: directed table, hand-written
// corner sequences and randomized traffic against a frame-level model.
module tb_rs_dsp_acc_drain;
    import rs_dsp_acc_pkg::*;

    localparam int     ACC_W = 40;
    localparam int     LEN_W = 8;
    localparam longint MASK  = (longint'(1) << ACC_W) - 1;
    localparam longint SMAX  = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint SMIN  = -(longint'(1) << (ACC_W - 1));

    logic clk = 1'b0;
    logic lreset;
    logic busy;
    logic drop_err;

    rs_dsp_acc_drain_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    rs_dsp_acc_drain #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .lreset   (lreset),
        .bus      (bus),
        .busy     (busy),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Frame-level reference: products of the open frame are kept in queues
    // and summed only when the frame length is reached.
    longint q_val[$];
    bit     q_sgn[$];
    int     m_len;
    bit     m_valid;
    longint m_out;
    bit     m_osat;
    bit     m_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint ext_m(input logic [37:0] zz, input bit zs);
        longint v;
        v = longint'({26'b0, zz});
        if (zs && zz[37]) v = v - (longint'(1) << 38);
        return v;
    endfunction

    function automatic longint as_signed(input longint a);
        return a[ACC_W-1] ? a - (longint'(1) << ACC_W) : a;
    endfunction

    task automatic frame_sum(output longint res, output bit rsat);
        longint a;
        longint t;
        rsat = 1'b0;
`ifdef RS_DSP_ACC_SAT_EN
        a = q_val[0] & MASK;
        for (int i = 1; i < q_val.size(); i++) begin
            if (q_sgn[i]) begin
                t = as_signed(a) + q_val[i];
                if (t > SMAX) begin t = SMAX; rsat = 1'b1; end
                if (t < SMIN) begin t = SMIN; rsat = 1'b1; end
                a = t & MASK;
            end else begin
                t = a + q_val[i];
                if (t > MASK) begin t = MASK; rsat = 1'b1; end
                a = t;
            end
        end
`else
        t = 0;
        foreach (q_val[i]) t = t + q_val[i];
        a = t & MASK;
`endif
        res = a;
    endtask

    task automatic model_reset();
        q_val.delete();
        q_sgn.delete();
        m_len   = 0;
        m_valid = 1'b0;
        m_out   = 0;
        m_osat  = 1'b0;
        m_drop  = 1'b0;
    endtask

    task automatic model_edge(input bit zv, input bit zs, input logic [37:0] zz,
                              input int len, input bit rdy);
        bit     drain;
        bit     done;
        longint res;
        bit     rsat;
        drain = m_valid && rdy;
        done  = 1'b0;
        res   = 0;
        rsat  = 1'b0;
        if (zv) begin
            if (q_val.size() == 0) m_len = ((len & 255) == 0) ? 1 : (len & 255);
            q_val.push_back(ext_m(zz, zs));
            q_sgn.push_back(zs);
            if (q_val.size() == m_len) begin
                frame_sum(res, rsat);
                done = 1'b1;
                q_val.delete();
                q_sgn.delete();
            end
        end
        if (done && (!m_valid || drain)) begin
            m_valid = 1'b1;
            m_out   = res;
            m_osat  = rsat;
        end else begin
            if (done)  m_drop  = 1'b1;
            if (drain) m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("acc_valid", bus.acc_valid, m_valid);
        check("busy", busy, q_val.size() != 0);
        check("drop_err", drop_err, m_drop);
        if (m_valid) begin
            check("acc_out", bus.acc_out, m_out);
            check("sat", bus.sat, m_osat);
        end
    endtask

    task automatic step(input bit zv, input bit zs, input logic [37:0] zz,
                        input int len, input bit rdy);
        lreset        = 1'b0;
        bus.z_valid   = zv;
        bus.z_signed  = zs;
        bus.z         = zz;
        bus.frame_len = LEN_W'(len);
        bus.acc_ready = rdy;
        @(posedge clk);
        model_edge(zv, zs, zz, len, rdy);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        lreset      = 1'b1;
        bus.z_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
        lreset = 1'b0;
    endtask

    typedef struct {
        bit          zv;
        bit          zs;
        logic [37:0] z;
        int          len;
        bit          rdy;
        bit          e_valid;
        logic [39:0] e_out;
        bit          e_busy;
    } vec_t;

    vec_t tbl[$];

    localparam logic [37:0] ZMAX  = 38'h3F_FFFF_FFFF;
    localparam logic [37:0] ZNEG  = 38'h20_0000_0000;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit          zv, zs, rdy;
        logic [63:0] r;
        logic [37:0] zz;

        lreset        = 1'b1;
        bus.z_valid   = 1'b0;
        bus.z_signed  = 1'b0;
        bus.z         = '0;
        bus.frame_len = '0;
        bus.acc_ready = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset();
        check("reset_acc_out", bus.acc_out, 64'd0);
        check("reset_sat", bus.sat, 64'd0);

        // Signed frame of four, then three single-product unsigned frames.
        tbl.push_back('{1, 1, 38'd10,         4, 1, 0, 40'd0,            1});
        tbl.push_back('{1, 1, 38'h3F_FFFF_FFFD, 4, 1, 0, 40'd0,          1});
        tbl.push_back('{1, 1, 38'd7,          4, 1, 0, 40'd0,            1});
        tbl.push_back('{1, 1, 38'h3F_FFFF_FFEC, 4, 1, 1, 40'hFF_FFFF_FFFA, 0});
        tbl.push_back('{0, 0, 38'd0,          4, 1, 0, 40'd0,            0});
        tbl.push_back('{1, 0, ZMAX,           0, 1, 1, 40'h3F_FFFF_FFFF, 0});
        tbl.push_back('{1, 0, ZMAX,           0, 1, 1, 40'h3F_FFFF_FFFF, 0});
        tbl.push_back('{1, 0, ZMAX,           0, 1, 1, 40'h3F_FFFF_FFFF, 0});
        tbl.push_back('{0, 0, 38'd0,          0, 1, 0, 40'd0,            0});
        foreach (tbl[i]) begin
            step(tbl[i].zv, tbl[i].zs, tbl[i].z, tbl[i].len, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), bus.acc_valid, tbl[i].e_valid);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_valid) check($sformatf("tbl%0d_out", i), bus.acc_out, tbl[i].e_out);
        end

        // Second result arrives while the first is still held: dropped.
        do_reset();
        step(1, 1, 38'd1, 2, 0);
        step(1, 1, 38'd2, 2, 0);
        check("hold_out", bus.acc_out, 64'd3);
        step(1, 1, 38'd3, 2, 0);
        step(1, 1, 38'd4, 2, 0);
        check("drop_out", bus.acc_out, 64'd3);
        check("drop_flag", drop_err, 64'd1);
        check("drop_valid", bus.acc_valid, 64'd1);
        step(0, 0, 38'd0, 2, 1);
        check("drain_valid", bus.acc_valid, 64'd0);
        step(0, 0, 38'd0, 2, 1);
        check("drop_sticky", drop_err, 64'd1);

        // Reset in the middle of a frame.
        step(1, 1, 38'd1, 4, 1);
        step(1, 1, 38'd1, 4, 1);
        check("mid_busy", busy, 64'd1);
        do_reset();
        check("rst_drop", drop_err, 64'd0);
        check("rst_valid", bus.acc_valid, 64'd0);
        check("rst_busy", busy, 64'd0);
        for (int i = 0; i < 4; i++) step(1, 1, 38'd1, 4, 1);
        check("post_rst_out", bus.acc_out, 64'd4);

        // Gapped frame with frame_len changed after the first product.
        step(0, 0, 38'd0, 3, 1);
        step(1, 1, 38'd5, 3, 1);
        step(0, 0, 38'd0, 1, 1);
        step(0, 0, 38'd0, 1, 1);
        step(1, 1, 38'd6, 1, 1);
        check("gap_busy", busy, 64'd1);
        check("gap_valid", bus.acc_valid, 64'd0);
        step(0, 0, 38'd0, 1, 1);
        step(1, 1, 38'd7, 1, 1);
        check("gap_valid_end", bus.acc_valid, 64'd1);
        check("gap_out", bus.acc_out, 64'd18);

        // Sixteen copies of -2^37 overflow a 40-bit signed accumulator.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 1, ZNEG, 16, 1);
`ifdef RS_DSP_ACC_SAT_EN
        check("sat_out", bus.acc_out, 64'h80_0000_0000);
        check("sat_flag", bus.sat, 64'd1);
`else
        check("wrap_out", bus.acc_out, 64'd0);
        check("wrap_sat", bus.sat, 64'd0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                zv  = ($urandom_range(0, 3) != 0);
                zs  = $urandom_range(0, 1);
                rdy = ($urandom_range(0, 2) != 0);
                r   = {$urandom, $urandom};
                zz  = ($urandom_range(0, 1) != 0) ? r[37:0] : 38'($urandom_range(0, 100));
                step(zv, zs, zz, $urandom_range(0, 5), rdy);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
